// File: rtl/fx2_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fx2_bus_arbiter
//  Description : Direction arbiter for the shared FX2 slave-FIFO bus.
//                Hands the bus between the EP2 command-receive path (RX)
//                and the EP6 upload path (TX). Switching happens only at
//                packet boundaries. Hold times are bounded. A turnaround
//                gap with fdata_oe low separates every direction change.
//  Revision    : 1.0  initial release
// ============================================================================
module fx2_bus_arbiter #(
   parameter int unsigned TURN_CYCLES = 2,     // idle cycles per direction change (0 acts as 1)
   parameter int unsigned RX_MAX_HOLD = 256,   // RX hold limit while TX waits
   parameter int unsigned TX_MAX_HOLD = 4096,  // TX hold limit while EP2 data waits
   parameter int unsigned CNT_W       = 13     // hold/turn counter width
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       ep2_has_data,
   input  logic       rx_busy,
   input  logic       tx_req,
   input  logic       tx_busy,
   input  logic       upload_lock,
   output logic       rw_switch,
   output logic       rx_grant,
   output logic       tx_grant,
   output logic       fdata_oe,
   output logic [2:0] arb_state
);

   // -------------------------------------------------------------------------
   // State encoding (the numeric values are visible on arb_state)
   // -------------------------------------------------------------------------
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RX      = 3'd1,
      ST_TURN_TX = 3'd2,
      ST_TX      = 3'd3,
      ST_TURN_RX = 3'd4
   } arb_state_t;

   // A zero-length turnaround would let both sides drive the bus together,
   // so it is promoted to one cycle.
   localparam int unsigned    C_TURN_EFF  = (TURN_CYCLES == 0) ? 1 : TURN_CYCLES;
   localparam logic [CNT_W-1:0] C_TURN_LAST = CNT_W'(C_TURN_EFF - 1);
   localparam logic [CNT_W-1:0] C_RX_HOLD   = CNT_W'(RX_MAX_HOLD);
   localparam logic [CNT_W-1:0] C_TX_HOLD   = CNT_W'(TX_MAX_HOLD);
   localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

   // -------------------------------------------------------------------------
   // Registers and their next-state values
   // -------------------------------------------------------------------------
   arb_state_t       state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             rw_switch_q, rw_switch_d;
   logic             rx_grant_q,  rx_grant_d;
   logic             tx_grant_q,  tx_grant_d;
   logic             fdata_oe_q,  fdata_oe_d;

   // Qualified exit conditions for the two owning states
   logic w_rx_release;
   logic w_tx_release;

   // Release conditions: never while the owner is mid-transfer; otherwise
   // when the owner has nothing left, or when the other side has waited for
   // the full hold limit. An active upload session cannot be preempted.
   always_comb begin
      w_rx_release = 1'b0;
      w_tx_release = 1'b0;
      if (!rx_busy) begin
         w_rx_release = !ep2_has_data || (tx_req && (cnt_q >= C_RX_HOLD));
      end
      if (!tx_busy) begin
         w_tx_release = !tx_req ||
                        (ep2_has_data && !upload_lock && (cnt_q >= C_TX_HOLD));
      end
   end

   // Next-state logic, shared hold/turn counter and output decode from the
   // next state, so every output changes on the edge that enters its state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q == C_CNT_MAX) ? cnt_q : (cnt_q + C_CNT_ONE);
      rw_switch_d = 1'b0;
      rx_grant_d  = 1'b0;
      tx_grant_d  = 1'b0;
      fdata_oe_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // RX wins a tie unless an upload session is holding priority
            if (tx_req && (upload_lock || !ep2_has_data)) begin
               state_d = ST_TURN_TX;
            end else if (ep2_has_data) begin
               state_d = ST_RX;
            end
         end

         ST_RX: begin
            if (w_rx_release) begin
               state_d = tx_req ? ST_TURN_TX : ST_IDLE;
            end
         end

         ST_TURN_TX: begin
            // TX is entered even if tx_req fell meanwhile; it then leaves
            // on the first cycle with tx_busy low.
            if (cnt_q >= C_TURN_LAST) begin
               state_d = ST_TX;
            end
         end

         ST_TX: begin
            if (w_tx_release) begin
               state_d = ST_TURN_RX;
            end
         end

         ST_TURN_RX: begin
            if (cnt_q >= C_TURN_LAST) begin
               state_d = ep2_has_data ? ST_RX : ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The counter measures time spent in the current state only
      if (state_d != state_q) begin
         cnt_d = '0;
      end

      case (state_d)
         ST_RX: begin
            rx_grant_d = 1'b1;
         end
         ST_TURN_TX, ST_TURN_RX: begin
            rw_switch_d = 1'b1;
         end
         ST_TX: begin
            rw_switch_d = 1'b1;
            tx_grant_d  = 1'b1;
            fdata_oe_d  = 1'b1;
         end
         default: begin
            rw_switch_d = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs; reset takes effect immediately
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rw_switch_q <= 1'b0;
         rx_grant_q  <= 1'b0;
         tx_grant_q  <= 1'b0;
         fdata_oe_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rw_switch_q <= rw_switch_d;
         rx_grant_q  <= rx_grant_d;
         tx_grant_q  <= tx_grant_d;
         fdata_oe_q  <= fdata_oe_d;
      end
   end

   assign rw_switch = rw_switch_q;
   assign rx_grant  = rx_grant_q;
   assign tx_grant  = tx_grant_q;
   assign fdata_oe  = fdata_oe_q;
   assign arb_state = state_q;

   // -------------------------------------------------------------------------
   // Bus-safety invariants
   // -------------------------------------------------------------------------
`ifndef SYNTHESIS
   a_grant_mutex : assert property (@(posedge Clk) disable iff (!Rst_n)
      !(rx_grant_q && tx_grant_q));

   a_oe_needs_tx_mux : assert property (@(posedge Clk) disable iff (!Rst_n)
      fdata_oe_q |-> rw_switch_q);

   a_rx_no_preempt : assert property (@(posedge Clk) disable iff (!Rst_n)
      (state_q == ST_RX && rx_busy) |=> (state_q == ST_RX));

   a_tx_no_preempt : assert property (@(posedge Clk) disable iff (!Rst_n)
      (state_q == ST_TX && tx_busy) |=> (state_q == ST_TX));

   // Each of the last C_TURN_EFF cycles before the FPGA starts driving (or
   // before RX is granted) must have had the opposite grant low.
   for (genvar k = 1; k <= C_TURN_EFF; k++) begin : g_turn_gap
      a_gap_to_tx : assert property (@(posedge Clk) disable iff (!Rst_n)
         $rose(fdata_oe_q) |-> $past(!rx_grant_q && !fdata_oe_q, k));
      a_gap_to_rx : assert property (@(posedge Clk) disable iff (!Rst_n)
         $rose(rx_grant_q) |-> $past(!tx_grant_q && !fdata_oe_q, k));
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fx2_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fx2_bus_arbiter
//  Description : Directed, table-driven bench for fx2_bus_arbiter plus
//                hand-written hold-limit, upload-lock and async-reset runs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fx2_bus_arbiter;

   logic       Clk;
   logic       Rst_n;
   logic       ep2_has_data;
   logic       rx_busy;
   logic       tx_req;
   logic       tx_busy;
   logic       upload_lock;
   logic       rw_switch;
   logic       rx_grant;
   logic       tx_grant;
   logic       fdata_oe;
   logic [2:0] arb_state;

   int checks   = 0;
   int failures = 0;

   // Observed outputs packed as {rw_switch, rx_grant, tx_grant, fdata_oe, arb_state}
   localparam logic [6:0] O_IDLE = 7'b0000_000;
   localparam logic [6:0] O_RX   = 7'b0100_001;
   localparam logic [6:0] O_TTX  = 7'b1000_010;
   localparam logic [6:0] O_TX   = 7'b1011_011;
   localparam logic [6:0] O_TRX  = 7'b1000_100;

   typedef struct packed {
      logic       ep2;
      logic       rxb;
      logic       treq;
      logic       txb;
      logic       lock;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs [0:18];

   fx2_bus_arbiter #(
      .TURN_CYCLES (2),
      .RX_MAX_HOLD (256),
      .TX_MAX_HOLD (4096),
      .CNT_W       (13)
   ) dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .ep2_has_data (ep2_has_data),
      .rx_busy      (rx_busy),
      .tx_req       (tx_req),
      .tx_busy      (tx_busy),
      .upload_lock  (upload_lock),
      .rw_switch    (rw_switch),
      .rx_grant     (rx_grant),
      .tx_grant     (tx_grant),
      .fdata_oe     (fdata_oe),
      .arb_state    (arb_state)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [6:0] obs();
      return {rw_switch, rx_grant, tx_grant, fdata_oe, arb_state};
   endfunction

   function automatic vec_t mk(input logic e, input logic rb, input logic tr,
                               input logic tb, input logic lk, input logic [6:0] ex);
      vec_t v;
      v.ep2 = e; v.rxb = rb; v.treq = tr; v.txb = tb; v.lock = lk; v.exp = ex;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act[6:0], exp[6:0]);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_in(input logic e, input logic rb, input logic tr,
                         input logic tb, input logic lk);
      ep2_has_data = e; rx_busy = rb; tx_req = tr; tx_busy = tb; upload_lock = lk;
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   initial begin
      int n;
      int left;

      //                ep2 rxb treq txb lock  expected
      vecs[0]  = mk(0, 0, 0, 0, 0, O_IDLE);  // idle stays idle
      vecs[1]  = mk(1, 0, 0, 0, 0, O_RX);    // EP2 data -> RX
      vecs[2]  = mk(1, 0, 1, 0, 0, O_RX);    // TX waits, hold not reached
      vecs[3]  = mk(0, 1, 1, 0, 0, O_RX);    // rx_busy blocks exit
      vecs[4]  = mk(0, 0, 1, 0, 0, O_TTX);   // EP2 empty, TX waiting
      vecs[5]  = mk(0, 0, 1, 0, 0, O_TTX);   // turnaround cycle 2
      vecs[6]  = mk(0, 0, 1, 0, 0, O_TX);    // TX granted, driving
      vecs[7]  = mk(0, 0, 0, 1, 0, O_TX);    // tx_busy blocks exit
      vecs[8]  = mk(1, 0, 0, 0, 0, O_TRX);   // TX done -> turnaround
      vecs[9]  = mk(1, 0, 0, 0, 0, O_TRX);   // turnaround cycle 2
      vecs[10] = mk(1, 0, 0, 0, 0, O_RX);    // EP2 data waiting -> RX
      vecs[11] = mk(0, 0, 0, 0, 0, O_IDLE);  // nothing pending -> IDLE
      vecs[12] = mk(1, 0, 1, 0, 1, O_TTX);   // tie with upload_lock -> TX side
      vecs[13] = mk(1, 0, 0, 0, 1, O_TTX);   // tx_req drops during turn
      vecs[14] = mk(1, 0, 0, 0, 1, O_TX);    // TX still entered
      vecs[15] = mk(0, 0, 0, 0, 0, O_TRX);   // leaves on first non-busy cycle
      vecs[16] = mk(0, 0, 0, 0, 0, O_TRX);
      vecs[17] = mk(0, 0, 0, 0, 0, O_IDLE);  // no EP2 data -> IDLE
      vecs[18] = mk(0, 0, 1, 0, 0, O_TTX);   // TX only request from IDLE

      // Reset state
      Rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0);
      @(posedge Clk);
      #1;
      chk("reset_outputs", 32'(obs()), 32'(O_IDLE));
      @(negedge Clk);
      Rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i <= 18; i++) begin
         set_in(vecs[i].ep2, vecs[i].rxb, vecs[i].treq, vecs[i].txb, vecs[i].lock);
         step();
         chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
      end

      // RX hold limit: TX waits, EP2 keeps data; RX held for hold 0..256
      do_reset();
      set_in(1, 0, 1, 0, 0);
      step();
      chk("hold_rx_entry", 32'(obs()), 32'(O_RX));
      n = 0;
      for (int c = 0; c < 400; c++) begin
         step();
         if (rx_grant) n++;
         else break;
      end
      chk_int("rx_hold_cycles", n, 256);
      chk("rx_hold_exit", 32'(obs()), 32'(O_TTX));
      step();
      step();
      chk("hold_tx_entry", 32'(obs()), 32'(O_TX));

      // TX past its hold limit but busy: must not leave until tx_busy drops
      set_in(1, 0, 1, 1, 0);
      left = 0;
      for (int c = 0; c < 4110; c++) begin
         step();
         if (arb_state != 3'd3) left++;
      end
      chk_int("tx_busy_no_preempt", left, 0);
      set_in(1, 0, 1, 0, 0);
      step();
      chk("tx_preempt_turn1", 32'(obs()), 32'(O_TRX));
      step();
      chk("tx_preempt_turn2", 32'(obs()), 32'(O_TRX));
      step();
      chk("tx_preempt_rx", 32'(obs()), 32'(O_RX));

      // Upload lock: TX kept for 10000 cycles despite EP2 data
      do_reset();
      set_in(1, 0, 1, 0, 1);
      repeat (3) step();
      chk("lock_tx_entry", 32'(obs()), 32'(O_TX));
      left = 0;
      for (int c = 0; c < 10000; c++) begin
         step();
         if (arb_state != 3'd3) left++;
      end
      chk_int("lock_no_preempt", left, 0);
      set_in(1, 0, 0, 0, 1);
      step();
      chk("lock_release_turn", 32'(obs()), 32'(O_TRX));
      step();
      step();
      chk("lock_release_rx", 32'(obs()), 32'(O_RX));

      // Asynchronous reset mid-TX
      do_reset();
      set_in(0, 0, 1, 1, 0);
      repeat (3) step();
      chk("pre_reset_tx", 32'(obs()), 32'(O_TX));
      @(negedge Clk);
      Rst_n = 1'b0;
      #1;
      chk("async_reset", 32'(obs()), 32'(O_IDLE));
      @(negedge Clk);
      set_in(0, 0, 0, 0, 0);
      Rst_n = 1'b1;
      step();
      chk("post_reset_idle", 32'(obs()), 32'(O_IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
